// File: rtl/conflict_checker_pkg.sv
// ---------------------------------------------------------------------------
// conflict_checker_pkg
// Shared definitions for the deferring batch conflict checker:
//   - state_e     : checker FSM states (IDLE, CHECK, EMIT)
//   - FLAG_*      : bit positions of the conflict flags (RAW, WAW, WAR, CAP)
//   - entryWidth  : width of one parked transaction {id, read map, write map}
// ---------------------------------------------------------------------------
package conflict_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_EMIT  = 2'd2
    } state_e;

    localparam int FLAG_RAW  = 0;
    localparam int FLAG_WAW  = 1;
    localparam int FLAG_WAR  = 2;
    localparam int FLAG_CAP  = 3;
    localparam int NUM_FLAGS = 4;

    // A parked transaction carries its owner ID plus both dependency maps.
    function automatic int entryWidth(input int idWidth, input int depWidth);
        return idWidth + 2 * depWidth;
    endfunction

endpackage

// File: rtl/dep_defer_fifo.sv
// ---------------------------------------------------------------------------
// dep_defer_fifo
// Synchronous FIFO that parks transactions which conflicted with the open
// batch. Head data is presented combinationally on dout_o.
// Ports:
//   clk, rst           clock, asynchronous active-high reset (pointers cleared)
//   push_i / din_i     write an entry; ignored (dropped) while full
//   pop_i  / dout_o    remove the head entry; ignored while empty
//   full_o, empty_o    occupancy flags
//   level_o            current number of stored entries
// Same-cycle push and pop are both honoured.
// ---------------------------------------------------------------------------
module dep_defer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [LVL_W-1:0] level_q;
    logic             doPush;
    logic             doPop;

    // Qualify requests against occupancy so a push at full is silently lost
    // and a pop at empty cannot corrupt the pointers.
    always_comb begin
        full_o  = (level_q == LVL_W'(DEPTH));
        empty_o = (level_q == '0);
        doPush  = push_i && !full_o;
        doPop   = pop_i && !empty_o;
        dout_o  = mem[rdPtr_q];
        level_o = level_q;
    end

    // Storage array has no reset: contents are meaningless once the
    // pointers are cleared, so reset discards every parked entry.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/conflict_checker_defer.sv
// ---------------------------------------------------------------------------
// conflict_checker_defer
// Checks each incoming transaction's read/write dependency bitmaps against the
// open batch's accumulated read and write sets (RAW, WAW, WAR) and against the
// batch capacity. Clean transactions are forwarded to the batch builder;
// conflicting ones are parked in a deferral FIFO and replayed once the batch
// is closed by batch_completed.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   s_axis_*                          ingress transaction (valid/ready + id/rd/wr)
//   m_axis_*                          forwarded transaction (valid/ready + id/rd/wr)
//   batch_completed                   pulse: close batch, clear sets, start replay
//   batch_txn_count                   transactions emitted into the open batch
//   defer_level                       deferral FIFO occupancy
//   drop_count                        txns lost because the FIFO was full (saturating)
// Optional feature macro CONFLICT_STATS_EN adds saturating counters
//   raw_conflicts, waw_conflicts, war_conflicts, cap_defers, filter_hits.
// ---------------------------------------------------------------------------
module conflict_checker_defer
    import conflict_checker_pkg::*;
#(
    parameter int DEP_WIDTH      = 1024,
    parameter int ID_WIDTH       = 64,
    parameter int DEFER_DEPTH    = 4,
    parameter int MAX_BATCH_TXNS = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic [ID_WIDTH-1:0]                   s_axis_tdata_owner_programID,
    input  logic [DEP_WIDTH-1:0]                  s_axis_tdata_read_dependencies,
    input  logic [DEP_WIDTH-1:0]                  s_axis_tdata_write_dependencies,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [ID_WIDTH-1:0]                   m_axis_tdata_owner_programID,
    output logic [DEP_WIDTH-1:0]                  m_axis_tdata_read_dependencies,
    output logic [DEP_WIDTH-1:0]                  m_axis_tdata_write_dependencies,
    input  logic                                  batch_completed,
    output logic [$clog2(MAX_BATCH_TXNS+1)-1:0]   batch_txn_count,
    output logic [$clog2(DEFER_DEPTH+1)-1:0]      defer_level,
    output logic [CNT_WIDTH-1:0]                  drop_count
`ifdef CONFLICT_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]                  raw_conflicts,
    output logic [CNT_WIDTH-1:0]                  waw_conflicts,
    output logic [CNT_WIDTH-1:0]                  war_conflicts,
    output logic [CNT_WIDTH-1:0]                  cap_defers,
    output logic [CNT_WIDTH-1:0]                  filter_hits
`endif
);

    localparam int ENTRY_W = entryWidth(ID_WIDTH, DEP_WIDTH);
    localparam int LVL_W   = $clog2(DEFER_DEPTH + 1);
    localparam int BC_W    = $clog2(MAX_BATCH_TXNS + 1);

    state_e                 state_q;
    logic                   mValid_q;
    logic [ID_WIDTH-1:0]    holdId_q;
    logic [DEP_WIDTH-1:0]   holdRd_q;
    logic [DEP_WIDTH-1:0]   holdWr_q;

    logic [DEP_WIDTH-1:0]   batchRd_q, batchRd_d;
    logic [DEP_WIDTH-1:0]   batchWr_q, batchWr_d;
    logic [BC_W-1:0]        batchCnt_q, batchCnt_d;
    logic [LVL_W-1:0]       replayLeft_q, replayLeft_d;
    logic [CNT_WIDTH-1:0]   dropCnt_q;

    logic [NUM_FLAGS-1:0]   flags;
    logic                   conflict;
    logic                   inIdle;
    logic                   replayGo;
    logic                   acceptIn;
    logic                   checkNow;
    logic                   emitFire;

    logic                   fifoPush;
    logic                   fifoPop;
    logic [ENTRY_W-1:0]     fifoDin;
    logic [ENTRY_W-1:0]     fifoHead;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [LVL_W-1:0]       fifoLevel;

    dep_defer_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEFER_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifoPush),
        .din_i   (fifoDin),
        .pop_i   (fifoPop),
        .dout_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifoLevel)
    );

    // Conflict detection on the held transaction and the handshake
    // qualifiers. A check is only acted on when no batch_completed arrives
    // in the same cycle; otherwise it is redone next cycle against the
    // freshly cleared sets.
    always_comb begin
        flags           = '0;
        flags[FLAG_RAW] = |(holdRd_q & batchWr_q);
        flags[FLAG_WAW] = |(holdWr_q & batchWr_q);
        flags[FLAG_WAR] = |(holdWr_q & batchRd_q);
        flags[FLAG_CAP] = (batchCnt_q == BC_W'(MAX_BATCH_TXNS));
        conflict        = |flags;

        inIdle          = (state_q == ST_IDLE);
        s_axis_tready   = inIdle && (replayLeft_q == '0);
        replayGo        = inIdle && (replayLeft_q != '0) && !fifoEmpty;
        acceptIn        = s_axis_tready && s_axis_tvalid;
        checkNow        = (state_q == ST_CHECK) && !batch_completed;
        emitFire        = (state_q == ST_EMIT) && m_axis_tready;

        fifoPop         = replayGo;
        fifoPush        = checkNow && conflict;
        fifoDin         = {holdId_q, holdRd_q, holdWr_q};
    end

    // Main FSM: IDLE loads the holding register (replay before new input),
    // CHECK decides defer vs. emit, EMIT holds the txn until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mValid_q <= 1'b0;
            holdId_q <= '0;
            holdRd_q <= '0;
            holdWr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (replayGo) begin
                        holdId_q <= fifoHead[ENTRY_W-1 -: ID_WIDTH];
                        holdRd_q <= fifoHead[2*DEP_WIDTH-1 -: DEP_WIDTH];
                        holdWr_q <= fifoHead[DEP_WIDTH-1:0];
                        state_q  <= ST_CHECK;
                    end else if (acceptIn) begin
                        holdId_q <= s_axis_tdata_owner_programID;
                        holdRd_q <= s_axis_tdata_read_dependencies;
                        holdWr_q <= s_axis_tdata_write_dependencies;
                        state_q  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (batch_completed) begin
                        state_q <= ST_CHECK;
                    end else if (conflict) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q  <= ST_EMIT;
                        mValid_q <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (m_axis_tready) begin
                        state_q  <= ST_IDLE;
                        mValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mValid_q <= 1'b0;
                end
            endcase
        end
    end

    // Batch bookkeeping. Closing the batch wins over a same-cycle emit, and
    // the replay budget is a snapshot of what is parked right now (minus an
    // entry leaving this cycle) so re-deferred replays wait a full batch.
    always_comb begin
        batchRd_d    = batchRd_q;
        batchWr_d    = batchWr_q;
        batchCnt_d   = batchCnt_q;
        replayLeft_d = replayLeft_q;
        if (batch_completed) begin
            batchRd_d    = '0;
            batchWr_d    = '0;
            batchCnt_d   = '0;
            replayLeft_d = fifoLevel - LVL_W'(fifoPop);
        end else begin
            if (emitFire) begin
                batchRd_d  = batchRd_q | holdRd_q;
                batchWr_d  = batchWr_q | holdWr_q;
                batchCnt_d = batchCnt_q + BC_W'(1);
            end
            if (replayGo) begin
                replayLeft_d = replayLeft_q - LVL_W'(1);
            end else if (inIdle && fifoEmpty) begin
                replayLeft_d = '0;
            end
        end
    end

    // Register the batch state and the always-present drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            batchRd_q    <= '0;
            batchWr_q    <= '0;
            batchCnt_q   <= '0;
            replayLeft_q <= '0;
            dropCnt_q    <= '0;
        end else begin
            batchRd_q    <= batchRd_d;
            batchWr_q    <= batchWr_d;
            batchCnt_q   <= batchCnt_d;
            replayLeft_q <= replayLeft_d;
            if (fifoPush && fifoFull && !(&dropCnt_q)) begin
                dropCnt_q <= dropCnt_q + CNT_WIDTH'(1);
            end
        end
    end

`ifdef CONFLICT_STATS_EN
    logic [CNT_WIDTH-1:0] rawCnt_q;
    logic [CNT_WIDTH-1:0] wawCnt_q;
    logic [CNT_WIDTH-1:0] warCnt_q;
    logic [CNT_WIDTH-1:0] capCnt_q;
    logic [CNT_WIDTH-1:0] hitCnt_q;

    // Per-flag statistics, bumped once per decided check and saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rawCnt_q <= '0;
            wawCnt_q <= '0;
            warCnt_q <= '0;
            capCnt_q <= '0;
            hitCnt_q <= '0;
        end else if (checkNow) begin
            if (flags[FLAG_RAW] && !(&rawCnt_q)) rawCnt_q <= rawCnt_q + CNT_WIDTH'(1);
            if (flags[FLAG_WAW] && !(&wawCnt_q)) wawCnt_q <= wawCnt_q + CNT_WIDTH'(1);
            if (flags[FLAG_WAR] && !(&warCnt_q)) warCnt_q <= warCnt_q + CNT_WIDTH'(1);
            if (flags[FLAG_CAP] && !(&capCnt_q)) capCnt_q <= capCnt_q + CNT_WIDTH'(1);
            if (conflict && !(&hitCnt_q))        hitCnt_q <= hitCnt_q + CNT_WIDTH'(1);
        end
    end

    assign raw_conflicts = rawCnt_q;
    assign waw_conflicts = wawCnt_q;
    assign war_conflicts = warCnt_q;
    assign cap_defers    = capCnt_q;
    assign filter_hits   = hitCnt_q;
`endif

    assign m_axis_tvalid                   = mValid_q;
    assign m_axis_tdata_owner_programID    = holdId_q;
    assign m_axis_tdata_read_dependencies  = holdRd_q;
    assign m_axis_tdata_write_dependencies = holdWr_q;
    assign batch_txn_count                 = batchCnt_q;
    assign defer_level                     = fifoLevel;
    assign drop_count                      = dropCnt_q;

endmodule

// File: tb/tb_conflict_checker_defer.sv
// ---------------------------------------------------------------------------
// tb_conflict_checker_defer
// Directed bench for conflict_checker_defer with narrow maps (16-bit
// dependency bitmaps, 8-bit IDs), default FIFO depth 4 and batch size 16.
// ---------------------------------------------------------------------------
module tb_conflict_checker_defer;

    localparam int DEP_W = 16;
    localparam int ID_W  = 8;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tready;
    logic [ID_W-1:0]  sId = '0;
    logic [DEP_W-1:0] sRd = '0;
    logic [DEP_W-1:0] sWr = '0;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b0;
    logic [ID_W-1:0]  mId;
    logic [DEP_W-1:0] mRd;
    logic [DEP_W-1:0] mWr;
    logic             batch_completed = 1'b0;
    logic [4:0]       batch_txn_count;
    logic [2:0]       defer_level;
    logic [CNT_W-1:0] drop_count;
`ifdef CONFLICT_STATS_EN
    logic [CNT_W-1:0] rawC, wawC, warC, capC, hitC;
`endif

    int checkCount = 0;
    int passCount  = 0;

    conflict_checker_defer #(
        .DEP_WIDTH      (DEP_W),
        .ID_WIDTH       (ID_W),
        .DEFER_DEPTH    (4),
        .MAX_BATCH_TXNS (16),
        .CNT_WIDTH      (CNT_W)
    ) dut (
        .clk                             (clk),
        .rst                             (rst),
        .s_axis_tvalid                   (s_axis_tvalid),
        .s_axis_tready                   (s_axis_tready),
        .s_axis_tdata_owner_programID    (sId),
        .s_axis_tdata_read_dependencies  (sRd),
        .s_axis_tdata_write_dependencies (sWr),
        .m_axis_tvalid                   (m_axis_tvalid),
        .m_axis_tready                   (m_axis_tready),
        .m_axis_tdata_owner_programID    (mId),
        .m_axis_tdata_read_dependencies  (mRd),
        .m_axis_tdata_write_dependencies (mWr),
        .batch_completed                 (batch_completed),
        .batch_txn_count                 (batch_txn_count),
        .defer_level                     (defer_level),
        .drop_count                      (drop_count)
`ifdef CONFLICT_STATS_EN
        ,
        .raw_conflicts                   (rawC),
        .waw_conflicts                   (wawC),
        .war_conflicts                   (warC),
        .cap_defers                      (capC),
        .filter_hits                     (hitC)
`endif
    );

    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge, where outputs are sampled
    // and new inputs are applied.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one transaction on s_axis and hold it until accepted. Returns
    // in the cycle after the handshake (the CHECK cycle).
    task automatic applyStimulus(input logic [ID_W-1:0] id, input logic [DEP_W-1:0] rd,
                                 input logic [DEP_W-1:0] wr);
        int n = 0;
        s_axis_tvalid = 1'b1;
        sId = id;
        sRd = rd;
        sWr = wr;
        while (!s_axis_tready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("s_tready", 64'(s_axis_tready), 64'd1);
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    // Wait for an emitted txn, check its contents, then accept it.
    task automatic expectEmit(input string tag, input logic [ID_W-1:0] id,
                              input logic [DEP_W-1:0] rd, input logic [DEP_W-1:0] wr);
        int n = 0;
        while (!m_axis_tvalid && n < 12) begin
            tick();
            n++;
        end
        checkOutput({tag, "_valid"}, 64'(m_axis_tvalid), 64'd1);
        if (m_axis_tvalid) begin
            checkOutput({tag, "_id"}, 64'(mId), 64'(id));
            checkOutput({tag, "_rd"}, 64'(mRd), 64'(rd));
            checkOutput({tag, "_wr"}, 64'(mWr), 64'(wr));
            m_axis_tready = 1'b1;
            tick();
            m_axis_tready = 1'b0;
        end
    endtask

    // Called in the CHECK cycle of a txn expected to be parked.
    task automatic expectDefer(input string tag, input int level);
        tick();
        checkOutput({tag, "_novalid"}, 64'(m_axis_tvalid), 64'd0);
        checkOutput({tag, "_level"}, 64'(defer_level), 64'(level));
    endtask

    task automatic pulseComplete();
        batch_completed = 1'b1;
        tick();
        batch_completed = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic stable;

        // Reset state
        tick();
        tick();
        checkOutput("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("rst_count",  64'(batch_txn_count), 64'd0);
        checkOutput("rst_level",  64'(defer_level), 64'd0);
        checkOutput("rst_drop",   64'(drop_count), 64'd0);
        checkOutput("rst_mdata",  64'({mId, mRd, mWr}), 64'd0);
        rst = 1'b0;
        tick();

        // T1: clean txn, N+2 latency
        applyStimulus(8'h01, 16'h0001, 16'h0002);
        checkOutput("t1_lat_n1", 64'(m_axis_tvalid), 64'd0);
        tick();
        checkOutput("t1_lat_n2", 64'(m_axis_tvalid), 64'd1);
        expectEmit("t1", 8'h01, 16'h0001, 16'h0002);
        checkOutput("t1_count", 64'(batch_txn_count), 64'd1);

        // T2: RAW and WAR defers, then replay after batch close
        applyStimulus(8'h02, 16'h0002, 16'h0000);
        expectDefer("t2_raw", 1);
        applyStimulus(8'h03, 16'h0000, 16'h0001);
        expectDefer("t2_war", 2);
        checkOutput("t2_count_hold", 64'(batch_txn_count), 64'd1);
        pulseComplete();
        checkOutput("t2_count_clr", 64'(batch_txn_count), 64'd0);
        expectEmit("t2_rep2", 8'h02, 16'h0002, 16'h0000);
        expectEmit("t2_rep3", 8'h03, 16'h0000, 16'h0001);
        tick();
        checkOutput("t2_level0", 64'(defer_level), 64'd0);
        checkOutput("t2_count2", 64'(batch_txn_count), 64'd2);

        // T3: WAW defers fill FIFO, fifth is dropped, ingress keeps flowing
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'(8'h04 + i), 16'h0000, 16'h0001);
            tick();
        end
        checkOutput("t3_level_full", 64'(defer_level), 64'd4);
        checkOutput("t3_drop", 64'(drop_count), 64'd1);
        applyStimulus(8'h09, 16'h0010, 16'h0020);
        expectEmit("t3_clean", 8'h09, 16'h0010, 16'h0020);
        pulseComplete();
        expectEmit("t3_rep4", 8'h04, 16'h0000, 16'h0001);
        repeat (10) tick();
        checkOutput("t3_redefer_level", 64'(defer_level), 64'd3);
        checkOutput("t3_redefer_novalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("t3_ready_back", 64'(s_axis_tready), 64'd1);
        checkOutput("t3_count", 64'(batch_txn_count), 64'd1);

        // T4: capacity limit
        doReset();
        checkOutput("t4_rst_drop", 64'(drop_count), 64'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(8'h20 + i), 16'(1 << i), 16'h0000);
            expectEmit("t4_emit", 8'(8'h20 + i), 16'(1 << i), 16'h0000);
        end
        checkOutput("t4_count16", 64'(batch_txn_count), 64'd16);
        applyStimulus(8'h30, 16'h0001, 16'h0000);
        expectDefer("t4_cap", 1);
        pulseComplete();
        checkOutput("t4_count_clr", 64'(batch_txn_count), 64'd0);
        expectEmit("t4_rep", 8'h30, 16'h0001, 16'h0000);
        checkOutput("t4_count1", 64'(batch_txn_count), 64'd1);

        // T5: backpressure, then close batch on the handshake cycle
        applyStimulus(8'h50, 16'h0100, 16'h0200);
        tick();
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!m_axis_tvalid || mId != 8'h50 || mRd != 16'h0100 || mWr != 16'h0200)
                stable = 1'b0;
        end
        checkOutput("t5_stable", 64'(stable), 64'd1);
        m_axis_tready = 1'b1;
        batch_completed = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        batch_completed = 1'b0;
        checkOutput("t5_count_clr", 64'(batch_txn_count), 64'd0);
        checkOutput("t5_valid_drop", 64'(m_axis_tvalid), 64'd0);
        applyStimulus(8'h51, 16'h0200, 16'h0100);
        expectEmit("t5_sets_clear", 8'h51, 16'h0200, 16'h0100);
        checkOutput("t5_count1", 64'(batch_txn_count), 64'd1);

        // T6: reset while holding a txn in EMIT with two parked
        applyStimulus(8'h60, 16'h0100, 16'h0000);
        expectDefer("t6_d0", 1);
        applyStimulus(8'h61, 16'h0100, 16'h0000);
        expectDefer("t6_d1", 2);
        applyStimulus(8'h62, 16'h0001, 16'h0002);
        tick();
        checkOutput("t6_in_emit", 64'(m_axis_tvalid), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("t6_mvalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("t6_level", 64'(defer_level), 64'd0);
        checkOutput("t6_count", 64'(batch_txn_count), 64'd0);
        checkOutput("t6_mdata", 64'({mId, mRd, mWr}), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("t6_ready", 64'(s_axis_tready), 64'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
